// File: rtl/ramb18e1_tdp.sv
// ramb18e1_tdp: RAMB18E1-style 16Kb true-dual-port RAM preloaded from INIT_xx; per port: bit address, enable, byte write enables, write data, latch/register sync resets, register enable, read data
module ramb18e1_tdp #(
  parameter int READ_WIDTH_A = 1,
  parameter int READ_WIDTH_B = 1,
  parameter string WRITE_MODE_A = "WRITE_FIRST",
  parameter string WRITE_MODE_B = "WRITE_FIRST",
  parameter int DOA_REG = 0,
  parameter int DOB_REG = 0,
  parameter logic [17:0] SRVAL_A = 18'h0,
  parameter logic [17:0] SRVAL_B = 18'h0,
  parameter logic [255:0] INIT_00 = '0, INIT_01 = '0, INIT_02 = '0, INIT_03 = '0,
  parameter logic [255:0] INIT_04 = '0, INIT_05 = '0, INIT_06 = '0, INIT_07 = '0,
  parameter logic [255:0] INIT_08 = '0, INIT_09 = '0, INIT_0A = '0, INIT_0B = '0,
  parameter logic [255:0] INIT_0C = '0, INIT_0D = '0, INIT_0E = '0, INIT_0F = '0,
  parameter logic [255:0] INIT_10 = '0, INIT_11 = '0, INIT_12 = '0, INIT_13 = '0,
  parameter logic [255:0] INIT_14 = '0, INIT_15 = '0, INIT_16 = '0, INIT_17 = '0,
  parameter logic [255:0] INIT_18 = '0, INIT_19 = '0, INIT_1A = '0, INIT_1B = '0,
  parameter logic [255:0] INIT_1C = '0, INIT_1D = '0, INIT_1E = '0, INIT_1F = '0,
  parameter logic [255:0] INIT_20 = '0, INIT_21 = '0, INIT_22 = '0, INIT_23 = '0,
  parameter logic [255:0] INIT_24 = '0, INIT_25 = '0, INIT_26 = '0, INIT_27 = '0,
  parameter logic [255:0] INIT_28 = '0, INIT_29 = '0, INIT_2A = '0, INIT_2B = '0,
  parameter logic [255:0] INIT_2C = '0, INIT_2D = '0, INIT_2E = '0, INIT_2F = '0,
  parameter logic [255:0] INIT_30 = '0, INIT_31 = '0, INIT_32 = '0, INIT_33 = '0,
  parameter logic [255:0] INIT_34 = '0, INIT_35 = '0, INIT_36 = '0, INIT_37 = '0,
  parameter logic [255:0] INIT_38 = '0, INIT_39 = '0, INIT_3A = '0, INIT_3B = '0,
  parameter logic [255:0] INIT_3C = '0, INIT_3D = '0, INIT_3E = '0, INIT_3F = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] ADDRARDADDR,
  input  logic        ENARDEN,
  input  logic [1:0]  WEA,
  input  logic [15:0] DIADI,
  input  logic        RSTRAMARSTRAM,
  input  logic        REGCEAREGCE,
  input  logic        RSTREGARSTREG,
  output logic [15:0] DOADO,
  input  logic [13:0] ADDRBWRADDR,
  input  logic        ENBWREN,
  input  logic [3:0]  WEBWE,
  input  logic [15:0] DIBDI,
  input  logic        RSTRAMB,
  input  logic        REGCEB,
  input  logic        RSTREGB,
  output logic [15:0] DOBDO
);
  localparam logic [16383:0] INIT = {
    INIT_3F, INIT_3E, INIT_3D, INIT_3C, INIT_3B, INIT_3A, INIT_39, INIT_38,
    INIT_37, INIT_36, INIT_35, INIT_34, INIT_33, INIT_32, INIT_31, INIT_30,
    INIT_2F, INIT_2E, INIT_2D, INIT_2C, INIT_2B, INIT_2A, INIT_29, INIT_28,
    INIT_27, INIT_26, INIT_25, INIT_24, INIT_23, INIT_22, INIT_21, INIT_20,
    INIT_1F, INIT_1E, INIT_1D, INIT_1C, INIT_1B, INIT_1A, INIT_19, INIT_18,
    INIT_17, INIT_16, INIT_15, INIT_14, INIT_13, INIT_12, INIT_11, INIT_10,
    INIT_0F, INIT_0E, INIT_0D, INIT_0C, INIT_0B, INIT_0A, INIT_09, INIT_08,
    INIT_07, INIT_06, INIT_05, INIT_04, INIT_03, INIT_02, INIT_01, INIT_00};
  localparam int WA = READ_WIDTH_A == 0 ? 1 : READ_WIDTH_A;
  localparam int WB = READ_WIDTH_B == 0 ? 1 : READ_WIDTH_B;
  logic [16383:0] mem = INIT;
  logic [13:0] addr [2];
  logic [13:0] base [2];
  logic [15:0] di [2], rd [2], wbit [2];
  logic [1:0] we [2];
  logic en [2], rstram [2], regce [2], rstreg [2];
  logic unused;
  assign addr = '{ADDRARDADDR, ADDRBWRADDR};
  assign di = '{DIADI, DIBDI};
  assign we = '{WEA, WEBWE[1:0]};
  assign en = '{ENARDEN, ENBWREN};
  assign rstram = '{RSTRAMARSTRAM, RSTRAMB};
  assign regce = '{REGCEAREGCE, REGCEB};
  assign rstreg = '{RSTREGARSTREG, RSTREGB};
  assign unused = ^WEBWE[3:2];
  function automatic int width(int p);
    return p == 0 ? WA : WB;
  endfunction
  // base is the bit address of the word's LSB: low log2(W) address bits cleared
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      base[p] = addr[p] & ~14'(width(p) - 1);
      for (int j = 0; j < 16; j++) begin
        rd[p][j] = j < width(p) ? mem[base[p] + 14'(j)] : 1'b0;
        wbit[p][j] = en[p] && j < width(p) && (width(p) == 16 ? we[p][j >= 8] : we[p][0]);
      end
    end
  end
  // port B is applied last so it wins when both ports write the same bit
  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 16; j++)
        if (wbit[p][j]) mem[base[p] + 14'(j)] <= di[p][j];
  for (genvar g = 0; g < 2; g++) begin : g_port
    localparam int W = g == 0 ? WA : WB;
    localparam bit RF = g == 0 ? WRITE_MODE_A == "READ_FIRST" : WRITE_MODE_B == "READ_FIRST";
    localparam bit NC = g == 0 ? WRITE_MODE_A == "NO_CHANGE" : WRITE_MODE_B == "NO_CHANGE";
    localparam bit REG = g == 0 ? DOA_REG != 0 : DOB_REG != 0;
    localparam logic [15:0] SRV = 16'(g == 0 ? SRVAL_A : SRVAL_B) & 16'((17'd1 << W) - 1);
    logic [15:0] lat = SRV;
    logic [15:0] oreg = SRV;
    logic [15:0] newd;
    // write-first view: freshly written bits merged over the unwritten bits of the word
    assign newd = (wbit[g] & di[g]) | (~wbit[g] & rd[g]);
    always_ff @(posedge clk or posedge rst)
      if (rst) lat <= SRV;
      else if (en[g]) lat <= rstram[g] ? SRV : ~|we[g] ? rd[g] : RF ? rd[g] : NC ? lat : newd;
    always_ff @(posedge clk or posedge rst)
      if (rst) oreg <= SRV;
      else if (rstreg[g]) oreg <= SRV;
      else if (regce[g]) oreg <= lat;
    if (g == 0) begin : g_a
      assign DOADO = REG ? oreg : lat;
    end else begin : g_b
      assign DOBDO = REG ? oreg : lat;
    end
  end
endmodule

// File: tb/tb_ramb18e1_tdp.sv
// tb_ramb18e1_tdp: scoreboard bench for ramb18e1_tdp across ROM, write-mode, output-register and reset configurations
module tb_ramb18e1_tdp;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  int cyc = 0, n_chk = 0, n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [13:0] aa [3], ab [3];
  logic ena [3], enb [3], rsa [3], rsb [3], rca [3], rcb [3], rra [3], rrb [3];
  logic [1:0] wea [3];
  logic [3:0] web [3];
  logic [15:0] dia [3], dib [3], doa [3], dob [3];
  typedef struct { int due; int sel; logic [15:0] v; string tag; } exp_t;
  exp_t q [$];
  ramb18e1_tdp #(.INIT_00({256{1'b1}}), .INIT_01({256{1'b1}}), .INIT_02({256{1'b1}}),
    .INIT_03({256{1'b1}}), .INIT_04(256'h3f8 << 216)) u0 (
    .clk(clk), .rst(rst), .ADDRARDADDR(aa[0]), .ENARDEN(ena[0]), .WEA(wea[0]), .DIADI(dia[0]),
    .RSTRAMARSTRAM(rsa[0]), .REGCEAREGCE(rca[0]), .RSTREGARSTREG(rra[0]), .DOADO(doa[0]),
    .ADDRBWRADDR(ab[0]), .ENBWREN(enb[0]), .WEBWE(web[0]), .DIBDI(dib[0]),
    .RSTRAMB(rsb[0]), .REGCEB(rcb[0]), .RSTREGB(rrb[0]), .DOBDO(dob[0]));
  ramb18e1_tdp #(.READ_WIDTH_A(16), .READ_WIDTH_B(16), .WRITE_MODE_B("NO_CHANGE"),
    .SRVAL_A(18'h0ffff), .SRVAL_B(18'h0beef), .INIT_00(256'h7777)) u1 (
    .clk(clk), .rst(rst), .ADDRARDADDR(aa[1]), .ENARDEN(ena[1]), .WEA(wea[1]), .DIADI(dia[1]),
    .RSTRAMARSTRAM(rsa[1]), .REGCEAREGCE(rca[1]), .RSTREGARSTREG(rra[1]), .DOADO(doa[1]),
    .ADDRBWRADDR(ab[1]), .ENBWREN(enb[1]), .WEBWE(web[1]), .DIBDI(dib[1]),
    .RSTRAMB(rsb[1]), .REGCEB(rcb[1]), .RSTREGB(rrb[1]), .DOBDO(dob[1]));
  ramb18e1_tdp #(.READ_WIDTH_A(16), .READ_WIDTH_B(16), .WRITE_MODE_A("READ_FIRST"),
    .DOA_REG(1), .SRVAL_A(18'h0a5a5)) u2 (
    .clk(clk), .rst(rst), .ADDRARDADDR(aa[2]), .ENARDEN(ena[2]), .WEA(wea[2]), .DIADI(dia[2]),
    .RSTRAMARSTRAM(rsa[2]), .REGCEAREGCE(rca[2]), .RSTREGARSTREG(rra[2]), .DOADO(doa[2]),
    .ADDRBWRADDR(ab[2]), .ENBWREN(enb[2]), .WEBWE(web[2]), .DIBDI(dib[2]),
    .RSTRAMB(rsb[2]), .REGCEB(rcb[2]), .RSTREGB(rrb[2]), .DOBDO(dob[2]));
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] obs(int sel);
    return sel[0] ? dob[sel / 2] : doa[sel / 2];
  endfunction
  task automatic expect_at(int lat, int sel, logic [15:0] v, string tag);
    q.push_back('{cyc + lat, sel, v, tag});
  endtask
  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due == cyc) begin
        chk(q[i].tag, obs(q[i].sel), q[i].v);
        q.delete(i);
      end
  task automatic tick();
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      ena[u] = 0; enb[u] = 0; wea[u] = 0; web[u] = 0;
      rsa[u] = 0; rsb[u] = 0; rra[u] = 0; rrb[u] = 0;
    end
  endtask
  task automatic pa(int u, logic [13:0] a, logic [1:0] we, logic [15:0] d);
    ena[u] = 1; aa[u] = a; wea[u] = we; dia[u] = d;
  endtask
  task automatic pb(int u, logic [13:0] a, logic [1:0] we, logic [15:0] d);
    enb[u] = 1; ab[u] = a; web[u] = {2'b00, we}; dib[u] = d;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int u = 0; u < 3; u++) begin
      aa[u] = 0; ab[u] = 0; ena[u] = 0; enb[u] = 0; wea[u] = 0; web[u] = 0;
      dia[u] = 0; dib[u] = 0; rsa[u] = 0; rsb[u] = 0; rca[u] = 1; rcb[u] = 1;
      rra[u] = 0; rrb[u] = 0;
    end
    #1;
    chk("pre_rst_u1a", doa[1], 16'hffff);
    chk("pre_rst_u1b", dob[1], 16'hbeef);
    chk("pre_rst_u2a", doa[2], 16'ha5a5);
    rst = 1;
    #1;
    chk("rst_u0a", doa[0], 16'h0000);
    chk("rst_u2a", doa[2], 16'ha5a5);
    tick();
    rst = 0;
    for (int a = 0; a <= 1250; a++) begin
      pa(0, 14'(a), 2'b00, 16'h0);
      expect_at(1, 0, (a < 1024 || (a >= 1243 && a <= 1249)) ? 16'h1 : 16'h0, $sformatf("rom@%0d", a));
      tick();
    end
    pa(0, 14'd7, 2'b01, 16'h0); pb(0, 14'd7, 2'b01, 16'h1);
    expect_at(1, 0, 16'h0, "both_wr_a"); expect_at(1, 1, 16'h1, "both_wr_b");
    tick();
    pa(0, 14'd7, 2'b00, 16'h0);
    expect_at(1, 0, 16'h1, "both_wr_b_wins");
    tick();
    pa(0, 14'd8, 2'b00, 16'h0); pb(0, 14'd8, 2'b01, 16'h0);
    expect_at(1, 0, 16'h1, "xport_a_old"); expect_at(1, 1, 16'h0, "xport_b_wr");
    tick();
    pa(0, 14'd8, 2'b00, 16'h0);
    expect_at(1, 0, 16'h0, "xport_a_new");
    tick();
    pa(1, 14'd80, 2'b01, 16'habcd);
    expect_at(1, 2, 16'h00cd, "wf_partial_w5");
    tick();
    pa(1, 14'd96, 2'b01, 16'habcd); pb(1, 14'd80, 2'b00, 16'h0);
    expect_at(1, 2, 16'h00cd, "wf_partial_w6"); expect_at(1, 3, 16'h00cd, "b_read_w5");
    tick();
    pa(1, 14'd80, 2'b11, 16'h1234); pb(1, 14'd0, 2'b00, 16'h0);
    expect_at(1, 2, 16'h1234, "write_first"); expect_at(1, 3, 16'h7777, "b_read_w0");
    tick();
    pb(1, 14'd96, 2'b11, 16'h1234); pa(1, 14'd96, 2'b00, 16'h0);
    expect_at(1, 3, 16'h7777, "no_change"); expect_at(1, 2, 16'h00cd, "xport_w6_old");
    tick();
    pa(1, 14'd96, 2'b00, 16'h0); pb(1, 14'd80, 2'b00, 16'h0);
    expect_at(1, 2, 16'h1234, "nc_mem_written"); expect_at(1, 3, 16'h1234, "b_read_w5_new");
    tick();
    pa(1, 14'd112, 2'b11, 16'h5555); rsa[1] = 1;
    expect_at(1, 2, 16'hffff, "rstram_a");
    tick();
    pa(1, 14'd112, 2'b00, 16'h0);
    expect_at(1, 2, 16'h5555, "rstram_still_writes");
    tick();
    pa(2, 14'd80, 2'b01, 16'habcd);
    expect_at(2, 4, 16'h0000, "rf_partial");
    tick();
    pa(2, 14'd80, 2'b11, 16'h1234);
    expect_at(2, 4, 16'h00cd, "read_first");
    tick();
    pa(2, 14'd80, 2'b00, 16'h0);
    expect_at(2, 4, 16'h1234, "reg_latency2");
    tick();
    pa(2, 14'd0, 2'b00, 16'h0);
    tick();
    rca[2] = 0;
    tick();
    chk("regce_hold", doa[2], 16'h1234);
    rca[2] = 1;
    tick();
    chk("regce_load", doa[2], 16'h0000);
    rra[2] = 1;
    tick();
    chk("rstreg", doa[2], 16'ha5a5);
    tick();
    tick();
    #2 rst = 1;
    #1;
    chk("async_rst_u1a", doa[1], 16'hffff);
    chk("async_rst_u1b", dob[1], 16'hbeef);
    #1 rst = 0;
    pa(1, 14'd80, 2'b00, 16'h0); pb(1, 14'd112, 2'b00, 16'h0); pa(0, 14'd7, 2'b00, 16'h0);
    expect_at(1, 2, 16'h1234, "mem_kept_u1a"); expect_at(1, 3, 16'h5555, "mem_kept_u1b");
    expect_at(1, 0, 16'h1, "mem_kept_u0");
    tick();
    tick();
    tick();
    chk("sb_drain", 16'(q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
